// File: rtl/dadda_mac_acc.sv
// Group accumulator behind the 32x32 Dadda multiplier: sums 64-bit products until a
// "last" beat, then presents sum / beat count / sticky overflow on a valid/ready port.
//
// state  | meaning
// S_ACC  | taking product beats, in_ready=1
// S_HOLD | finished group presented, out_valid=1, input stalled
module dadda_mac_acc #(
  parameter int ACC_W = 72,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic {S_ACC = 1'b0, S_HOLD = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic [ACC_W:0]   sum;
  logic [CNT_W-1:0] cnt_inc;
  logic             ovf_new;
  logic             in_take;
  logic             out_take;

  // Handshake flags come from state only, so no input-to-output combinational path.
  assign in_ready  = (state_q == S_ACC);
  assign out_valid = (state_q == S_HOLD);
  assign in_take   = in_valid & in_ready;
  assign out_take  = out_valid & out_ready;

  always_comb begin
    sum     = {1'b0, acc_q} + {{(ACC_W + 1 - 64){1'b0}}, in_prod};
    cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    ovf_new = ovf_q | sum[ACC_W];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ACC:   if (in_take && in_last) state_d = S_HOLD;
      S_HOLD:  if (out_take) state_d = S_ACC;
      default: state_d = S_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_ACC;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_acc   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (in_take) begin
        if (in_last) begin
          out_acc   <= sum[ACC_W-1:0];
          out_ovf   <= ovf_new;
          out_count <= cnt_inc;
          acc_q     <= '0;
          cnt_q     <= '0;
          ovf_q     <= 1'b0;
        end else begin
          acc_q <= sum[ACC_W-1:0];
          ovf_q <= ovf_new;
          cnt_q <= cnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_dadda_mac_acc.sv
// Bench for dadda_mac_acc: three instances (default, ACC_W=64, CNT_W=2) share one
// stimulus stream; each group is checked against a plain-arithmetic sum model.
module tb_dadda_mac_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_last;
  logic        out_ready;
  logic [63:0] in_prod;

  logic        a_in_ready, a_out_valid, a_ovf;
  logic [71:0] a_acc;
  logic [15:0] a_cnt;
  logic        b_in_ready, b_out_valid, b_ovf;
  logic [63:0] b_acc;
  logic [15:0] b_cnt;
  logic        c_in_ready, c_out_valid, c_ovf;
  logic [71:0] c_acc;
  logic [1:0]  c_cnt;

  int errors = 0;
  int checks = 0;
  logic [63:0] grp[$];

  always #5 clk = ~clk;

  dadda_mac_acc #(.ACC_W(72), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_prod(in_prod), .in_last(in_last), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_acc(a_acc), .out_count(a_cnt), .out_ovf(a_ovf));

  dadda_mac_acc #(.ACC_W(64), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_prod(in_prod), .in_last(in_last), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_acc(b_acc), .out_count(b_cnt), .out_ovf(b_ovf));

  dadda_mac_acc #(.ACC_W(72), .CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_prod(in_prod), .in_last(in_last), .out_valid(c_out_valid),
    .out_ready(out_ready), .out_acc(c_acc), .out_count(c_cnt), .out_ovf(c_ovf));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic put(input logic [63:0] p, input logic last, input int gap);
    int guard;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = last;
    guard    = 0;
    while (!a_in_ready) begin
      if (guard == 200) begin
        check("in_ready_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      guard++;
      @(negedge clk);
    end
    grp.push_back(p);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    logic [127:0] s;
    int n;
    s = '0;
    foreach (grp[i]) s += 128'(grp[i]);
    n = grp.size();
    check({tag, "_a_acc"}, a_acc, s[71:0]);
    check({tag, "_a_ovf"}, a_ovf, |s[127:72]);
    check({tag, "_a_cnt"}, a_cnt, (n > 65535) ? 65535 : n);
    check({tag, "_b_acc"}, b_acc, s[63:0]);
    check({tag, "_b_ovf"}, b_ovf, |s[127:64]);
    check({tag, "_b_cnt"}, b_cnt, (n > 65535) ? 65535 : n);
    check({tag, "_c_acc"}, c_acc, s[71:0]);
    check({tag, "_c_cnt"}, c_cnt, (n > 3) ? 3 : n);
    check({tag, "_valid"}, {a_out_valid, b_out_valid, c_out_valid}, 3'b111);
    check({tag, "_in_rdy"}, {a_in_ready, b_in_ready, c_in_ready}, 3'b000);
  endtask

  // Entered at the negedge right after the last beat was accepted.
  task automatic expect_out(input int stall);
    logic [71:0] held;
    int guard;
    check("latency", a_out_valid, 1);
    guard = 0;
    while (!a_out_valid && guard < 20) begin
      guard++;
      @(negedge clk);
    end
    check_outputs("grp");
    held = a_acc;
    out_ready = 1'b0;
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check_outputs("stall");
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("drop_valid", {a_out_valid, b_out_valid, c_out_valid}, 3'b000);
    check("rdy_back", {a_in_ready, b_in_ready, c_in_ready}, 3'b111);
    check("acc_kept", a_acc, held);
    grp.delete();
  endtask

  initial begin
    logic [63:0] p;
    logic [31:0] x, y;
    int len;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_prod = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_valid", a_out_valid, 0);
    check("rst_in_rdy", a_in_ready, 1);
    check("rst_acc", a_acc, 0);
    check("rst_cnt", a_cnt, 0);
    check("rst_ovf", a_ovf, 0);

    put(3, 0, 0); put(5, 0, 0); put(7, 1, 0);
    check("t1_acc", a_acc, 15);
    check("t1_cnt", a_cnt, 3);
    expect_out(0);

    put(64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    check("t2_acc", a_acc, 72'h00_FFFF_FFFF_FFFF_FFFF);
    check("t2_cnt", a_cnt, 1);
    expect_out(0);

    put(64'hFFFF_FFFF_FFFF_FFFF, 0, 0); put(2, 1, 0);
    check("t3_b_acc", b_acc, 1);
    check("t3_b_ovf", b_ovf, 1);
    check("t3_a_acc", a_acc, 72'h01_0000_0000_0000_0001);
    expect_out(0);
    put(4, 1, 0);
    check("t3_b_acc2", b_acc, 4);
    check("t3_b_ovf2", b_ovf, 0);
    expect_out(0);

    put(100, 0, 0); put(200, 1, 0);
    in_valid = 1'b1; in_prod = 42; in_last = 1'b1;
    expect_out(5);
    put(42, 1, 0);
    check("t4_acc", a_acc, 42);
    check("t4_cnt", a_cnt, 1);
    expect_out(0);

    put(10, 0, 0); put(20, 0, 0);
    rst = 1'b1; grp.delete();
    @(negedge clk);
    rst = 1'b0;
    put(1, 1, 0);
    check("t5_acc", a_acc, 1);
    check("t5_cnt", a_cnt, 1);
    expect_out(0);

    put(9, 1, 0);
    rst = 1'b1; grp.delete();
    @(negedge clk);
    rst = 1'b0;
    check("rstp_valid", a_out_valid, 0);
    check("rstp_acc", a_acc, 0);
    check("rstp_in_rdy", a_in_ready, 1);

    for (int k = 0; k < 5; k++) put(1, (k == 4), 0);
    check("t6_c_cnt", c_cnt, 3);
    check("t6_c_acc", c_acc, 5);
    check("t6_a_cnt", a_cnt, 5);
    expect_out(0);

    for (int g = 0; g < 1000; g++) begin
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        x = $urandom;
        y = $urandom;
        p = 64'(x) * 64'(y);
        if ($urandom_range(0, 7) == 0) p = 64'hFFFF_FFFF_FFFF_FFFF;
        put(p, (k == len - 1), $urandom_range(0, 1));
      end
      expect_out($urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
